// File: rtl/chunked_addsub.sv
// Registered add/subtract unit: a WIDTH-bit operation is processed CHUNK bits per
// cycle, LSB chunk first, with the ripple carry held in a register between cycles.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [KW-1:0]     k_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;

  logic [CHUNK-1:0]  slice_a_s;
  logic [CHUNK-1:0]  slice_b_s;
  logic [CHUNK-1:0]  slice_sum_s;
  logic              slice_carry_s;
  logic              msb_carry_in_s;
  logic [WIDTH-1:0]  sum_next_s;
  logic              accept_s;

  assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign accept_s = in_valid & in_ready;

  // Select operand slice k, add it with the held carry, and merge the result into sum.
  always_comb begin
    slice_a_s  = {CHUNK{1'b0}};
    slice_b_s  = {CHUNK{1'b0}};
    sum_next_s = sum;
    for (int i = 0; i < N; i++) begin
      if (k_r == i[KW-1:0]) begin
        slice_a_s = a_r[i*CHUNK +: CHUNK];
        slice_b_s = b_r[i*CHUNK +: CHUNK];
      end else begin
        slice_a_s = slice_a_s;
        slice_b_s = slice_b_s;
      end
    end
    {slice_carry_s, slice_sum_s} = {1'b0, slice_a_s} + {1'b0, slice_b_s}
                                 + {{CHUNK{1'b0}}, carry_r};
    // Carry into the top bit of the slice; only meaningful on the MSB chunk.
    msb_carry_in_s = slice_a_s[CHUNK-1] ^ slice_b_s[CHUNK-1] ^ slice_sum_s[CHUNK-1];
    for (int i = 0; i < N; i++) begin
      if (k_r == i[KW-1:0]) begin
        sum_next_s[i*CHUNK +: CHUNK] = slice_sum_s;
      end else begin
        sum_next_s[i*CHUNK +: CHUNK] = sum[i*CHUNK +: CHUNK];
      end
    end
  end

  // Control FSM, operand capture, chunk datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      k_r       <= {KW{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept_s) begin
      a_r       <= a;
      b_r       <= sub ? ~b : b;
      carry_r   <= carryin;
      k_r       <= {KW{1'b0}};
      state_r   <= BUSY;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        BUSY: begin
          sum     <= sum_next_s;
          carry_r <= slice_carry_s;
          if (k_r == K_LAST) begin
            carryout  <= slice_carry_s;
            overflow  <= msb_carry_in_s ^ slice_carry_s;
            zero      <= (sum_next_s == {WIDTH{1'b0}});
            k_r       <= {KW{1'b0}};
            state_r   <= DONE;
            out_valid <= 1'b1;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          k_r       <= {KW{1'b0}};
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed and randomized checks of chunked_addsub (N=4 and N=1 instances) against a
// whole-word arithmetic reference model.
module tb_chunked_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, out_ready, in_valid1, out_ready1;
  logic [15:0] a, b;
  logic        carryin, sub;
  logic        in_ready, out_valid, carryout, overflow, zero;
  logic [15:0] sum;
  logic        in_ready1, out_valid1, carryout1, overflow1, zero1;
  logic [15:0] sum1;

  int tests = 0;
  int fails = 0;

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carryin(carryin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .carryin(carryin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .carryout(carryout1), .overflow(overflow1), .zero(zero1)
  );

  // Reference: {zero, overflow, carryout, sum} from whole-word arithmetic.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    logic [15:0] yy;
    logic [16:0] full;
    logic        v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, c};
    v    = (x[15] == yy[15]) && (full[15] != x[15]);
    return {(full[15:0] == 16'd0), v, full[16], full[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] x, input logic [15:0] y,
                       input logic s, input logic c);
    a = x; b = y; sub = s; carryin = c; in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic wait_done(input int n, input bit toggle, input string tag);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (toggle) begin
        a = ~a; b = b ^ 16'h5A5A; sub = ~sub; carryin = ~carryin;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, n);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic c, input logic [18:0] exp, input string tag);
    start(x, y, s, c);
    wait_done(4, 1'b0, tag);
    chk(tag, {13'd0, zero, overflow, carryout, sum}, {13'd0, exp});
    release_result();
  endtask

  initial begin
    logic [18:0] exp_r;
    logic [15:0] rx, ry;
    logic        rs, rc;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    a = 16'd0; b = 16'd0; sub = 1'b0; carryin = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {13'd0, zero, overflow, carryout, sum}, 32'd0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h0100}, "add_ripple");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}, "add_wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000}, "add_ovf");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE}, "sub_neg");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 16'h7FFF}, "sub_ovf");

    // Backpressure: hold the result for 5 cycles, then release with a new accept.
    exp_r = model(16'h1234, 16'h0FF0, 1'b0, 1'b1);
    start(16'h1234, 16'h0FF0, 1'b0, 1'b1);
    wait_done(4, 1'b0, "bp_first");
    for (int i = 0; i < 5; i++) begin
      a = a + 16'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_result", {13'd0, zero, overflow, carryout, sum}, {13'd0, exp_r});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_r = model(16'hA5A5, 16'h5A5B, 1'b1, 1'b1);
    start(16'hA5A5, 16'h5A5B, 1'b1, 1'b1);
    chk("bp_accept_out_valid", {31'd0, out_valid}, 32'd0);
    wait_done(4, 1'b0, "bp_second");
    chk("bp_second", {13'd0, zero, overflow, carryout, sum}, {13'd0, exp_r});
    release_result();

    // Random operands, with inputs toggling every cycle while the unit is busy.
    for (int i = 0; i < 25; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom_range(1, 0));
      rc = 1'($urandom_range(1, 0));
      if (i == 0) begin rx = 16'h0000; ry = 16'hFFFF; rs = 1'b1; rc = 1'b1; end
      exp_r = model(rx, ry, rs, rc);
      start(rx, ry, rs, rc);
      wait_done(4, 1'b1, "rand");
      chk("rand_result", {13'd0, zero, overflow, carryout, sum}, {13'd0, exp_r});
      release_result();
    end

    // Reset while BUSY at k=2 on the N=4 instance.
    start(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5555}, "after_rst");

    // N=1 instance: one-cycle latency and reset while BUSY.
    a = 16'h1111; b = 16'h2222; sub = 1'b0; carryin = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("n1_accept_out_valid", {31'd0, out_valid1}, 32'd0);
    @(posedge clk); #1;
    chk("n1_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_result", {13'd0, zero1, overflow1, carryout1, sum1}, {13'd0, 19'h03333});
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("n1_release", {31'd0, out_valid1}, 32'd0);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("n1_midrst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("n1_midrst_sum", {16'd0, sum1}, 32'd0);
    chk("n1_midrst_in_ready", {31'd0, in_ready1}, 32'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h4321; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_after_rst_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_after_rst", {13'd0, zero1, overflow1, carryout1, sum1}, {13'd0, 19'h05555});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised, registered add/subtract unit that processes a WIDTH-bit operation CHUNK bits per cycle, LSB chunk first, with a ripple carry held in a register between cycles. It extends the team's registered 4-bit adder with carry-in/carry-out. The additions are:
- generic width
- subtract mode
- valid/ready handshakes on input and output
- signed-overflow and zero flags

It sits between operand producers and result consumers wherever a wide adder would otherwise close timing poorly.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK cycles per operation (N ≥ 1)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carryin  input  1  carry into bit 0 (acts as not-borrow in subtract mode)
- sub  input  1  0: A+B+carryin; 1: A+~B+carryin
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer takes result this cycle
- sum  output  WIDTH  result, modulo 2^WIDTH
- carryout  output  1  raw carry out of bit WIDTH-1
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
- zero  output  1  sum == 0

## Operation
- The state machine has three states: IDLE, BUSY and DONE. A chunk counter k runs 0..N-1.
- **Reset.** Asserting rst low forces the following immediately, independent of clk:
  - state = IDLE, k = 0
  - sum = 0, carryout = 0, overflow = 0, zero = 0, out_valid = 0
  - any in-flight operation is discarded
- **in_ready.** in_ready = (state == IDLE) | (state == DONE & out_ready). It is combinational from state, so it reads 1 while in reset.
- **Accept.** An accept happens when in_valid & in_ready at a rising edge. On accept:
  - register a
  - register b, or ~b when sub = 1
  - load the internal carry from carryin
  - clear k to 0
  - enter BUSY
- Operands are sampled only at accept. Changes on a, b, sub and carryin while BUSY or DONE are ignored.
- **BUSY.** Each cycle computes {c, s} = a[k] + b'[k] + carry over CHUNK-bit slice k:
  - write s into sum slice k
  - store c as the carry
  - increment k
  - On k == N-1: write carryout = c and overflow = (carry into MSB) XOR c. Write zero from the full result. Clear k and enter DONE.
- **sum during BUSY.** Slices not yet computed hold their previous value. sum is only defined while out_valid = 1.
- **DONE.**
  - out_valid = 1; sum and all flags hold stable until out_ready = 1.
  - out_ready = 1 with no accept: go to IDLE and clear out_valid.
  - out_ready = 1 with in_valid = 1: accept new operands on the same edge and go straight to BUSY.
- **Width rules.** The arithmetic is unsigned modulo 2^WIDTH. overflow interprets the operands as signed. carryout in subtract mode equals not-borrow: 1 when A ≥ B + (1-carryin) unsigned.

## Timing
- **Latency.** An accept at edge t gives out_valid = 1 after edge t+N. For N = 1 that is the edge after the accept.
- **Throughput.** The unit completes one operation per N+1 cycles under continuous in_valid and out_ready.
- **Output registers.** All outputs except in_ready are registered. No combinational path exists from a, b, carryin or sub to any output.
- **Simultaneous events.** rst low overrides every handshake. A result in DONE that is dropped by reset is never presented again.

## Test plan
- WIDTH=16, CHUNK=4, a=0x00FF, b=0x0001, sub=0, carryin=0 → sum=0x0100, carryout=0, overflow=0, zero=0. out_valid rises exactly 4 edges after accept. The carry propagates across chunk boundaries.
- a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, carryout=1, zero=1, overflow=0. With a=0x7FFF, b=0x0001 → sum=0x8000, overflow=1, carryout=0.
- sub=1, carryin=1, a=0x0005, b=0x0007 → sum=0xFFFE, carryout=0, overflow=0. With a=0x8000, b=0x0001 → sum=0x7FFF, carryout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum and flags are unchanged and in_ready=0. Then raise out_ready=1 together with in_valid=1 → the new operands are accepted on that edge and the next result is correct.
- Operand change during BUSY: toggle a, b and sub every cycle after accept → the result matches the operands sampled at accept.
- Reset mid-BUSY (k=2) → out_valid=0, sum=0 and in_ready=1 immediately, before the next clk edge. The next operation, 0x1234+0x4321, gives 0x5555. Repeat the check with CHUNK=16 (N=1) for 1-cycle latency.
